// File: rtl/program_flow_unit_pkg.sv
// rtl/program_flow_unit_pkg.sv - shared defaults, PC source encoding and helpers for the program flow unit
package program_flow_unit_pkg;

  localparam int DEF_PC_WIDTH       = 8;
  localparam int DEF_STACK_DEPTH    = 16;
  localparam int DEF_FLAG_WIDTH     = 4;
  localparam int DEF_NUM_IRQ        = 4;
  localparam int DEF_RST_VECTOR     = 0;
  localparam int DEF_INT_VEC_BASE   = 1;
  localparam int DEF_INT_VEC_STRIDE = 2;

  // Where the next PC comes from, in decreasing priority order
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RST,
    PC_VEC,
    PC_DBG,
    PC_JUMP,
    PC_RET,
    PC_INC
  } pc_src_e;

  // Channel index width; a single channel still gets a 1-bit id
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Untruncated vector address of channel n; caller truncates to PC width
  function automatic int vec_addr(input int base, input int stride, input int n);
    return base + n * stride;
  endfunction

endpackage

// File: rtl/program_flow_unit_if.sv
// rtl/program_flow_unit_if.sv - controller-side bus of the program flow unit
interface program_flow_unit_if
  import program_flow_unit_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int FLAG_WIDTH  = DEF_FLAG_WIDTH,
  parameter int NUM_IRQ     = DEF_NUM_IRQ
);
  localparam int IDW = id_width(NUM_IRQ);
  localparam int EW  = PC_WIDTH + FLAG_WIDTH + 2;
  localparam int LW  = $clog2(STACK_DEPTH) + 1;

  logic                  initialize;
  logic                  fetch;
  logic                  ex_jump;
  logic                  ex_call;
  logic                  ex_ret_sub;
  logic                  ex_ret_int;
  logic                  int_poll;
  logic                  ie_set;
  logic                  ie_clr;
  logic [PC_WIDTH-1:0]   jump_addr;
  logic [NUM_IRQ-1:0]    irq;
  logic [NUM_IRQ-1:0]    irq_mask;
  logic [FLAG_WIDTH-1:0] flags_in;
  logic [FLAG_WIDTH-1:0] flags_out;
  logic                  flags_wr;
  logic                  dbg_is_brk;
  logic                  dbg_pc_wr;
  logic [PC_WIDTH-1:0]   dbg_data_in;
  logic                  dbg_clr_err;
  logic [PC_WIDTH-1:0]   pc;
  logic                  int_take;
  logic [IDW-1:0]        int_id;
  logic                  flag_ie;
  logic                  flag_if;
  logic [EW-1:0]         stack_top;
  logic [LW-1:0]         stack_level;
  logic                  stack_ovf;
  logic                  stack_unf;

  modport master (
    output initialize, fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int, int_poll,
           ie_set, ie_clr, jump_addr, irq, irq_mask, flags_in,
           dbg_is_brk, dbg_pc_wr, dbg_data_in, dbg_clr_err,
    input  flags_out, flags_wr, pc, int_take, int_id, flag_ie, flag_if,
           stack_top, stack_level, stack_ovf, stack_unf
  );

  modport slave (
    input  initialize, fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int, int_poll,
           ie_set, ie_clr, jump_addr, irq, irq_mask, flags_in,
           dbg_is_brk, dbg_pc_wr, dbg_data_in, dbg_clr_err,
    output flags_out, flags_wr, pc, int_take, int_id, flag_ie, flag_if,
           stack_top, stack_level, stack_ovf, stack_unf
  );

endinterface

// File: rtl/program_flow_unit_flow_stack.sv
// rtl/program_flow_unit_flow_stack.sv - bounded LIFO that silently ignores push-when-full and pop-when-empty
module program_flow_unit_flow_stack #(
  parameter int DATA_WIDTH = 14,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_top,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_full,
  output logic                    o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]         r_level;
  logic [AW-1:0]         w_wr_idx;
  logic [AW-1:0]         w_rd_idx;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty & ~i_push;
  // When full the low bits wrap to 0, so DEPTH-1 still addresses the top entry
  assign w_wr_idx  = r_level[AW-1:0];
  assign w_rd_idx  = r_level[AW-1:0] - AW'(1);
  assign o_top     = o_empty ? '0 : r_mem[w_rd_idx];
  assign o_level   = r_level;

  // Occupancy counter; clear has priority over any stack operation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else if (w_do_push) begin
      r_level <= r_level + LW'(1);
    end else if (w_do_pop) begin
      r_level <= r_level - LW'(1);
    end
  end

  // Entry storage; contents above the level are don't-care
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/program_flow_unit.sv
// rtl/program_flow_unit.sv - PC, call/interrupt stack, IE/IF flags and vectored interrupt front end
module program_flow_unit
  import program_flow_unit_pkg::*;
#(
  parameter int                 PC_WIDTH       = DEF_PC_WIDTH,
  parameter int                 STACK_DEPTH    = DEF_STACK_DEPTH,
  parameter int                 FLAG_WIDTH     = DEF_FLAG_WIDTH,
  parameter int                 NUM_IRQ        = DEF_NUM_IRQ,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE       = '0,
  parameter int                 RST_VECTOR     = DEF_RST_VECTOR,
  parameter int                 INT_VEC_BASE   = DEF_INT_VEC_BASE,
  parameter int                 INT_VEC_STRIDE = DEF_INT_VEC_STRIDE
) (
  input logic               clk,
  input logic               rst,
  program_flow_unit_if.slave bus
);
  localparam int IDW       = id_width(NUM_IRQ);
  localparam int EW        = PC_WIDTH + FLAG_WIDTH + 2;
  localparam int LW        = $clog2(STACK_DEPTH) + 1;
  localparam int OFS_FLAGS = PC_WIDTH;
  localparam int OFS_IE    = PC_WIDTH + FLAG_WIDTH;
  localparam int OFS_IF    = OFS_IE + 1;
  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RST_VECTOR);

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_ie;
  logic                r_if;
  logic                r_ovf;
  logic                r_unf;
  logic [NUM_IRQ-1:0]  r_irq_prev;
  logic [NUM_IRQ-1:0]  r_edge_pend;

  logic                w_reset;
  logic [NUM_IRQ-1:0]  w_pending;
  logic [NUM_IRQ-1:0]  w_req;
  logic [NUM_IRQ-1:0]  w_take_mask;
  logic                w_int_take;
  logic [IDW-1:0]      w_int_id;
  logic [PC_WIDTH-1:0] w_vec;
  pc_src_e             w_src;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic                w_push;
  logic                w_pop;
  logic                w_restore;
  logic                w_ovf_evt;
  logic                w_unf_evt;
  logic                w_ie_next;
  logic                w_if_next;
  logic [EW-1:0]       w_push_data;
  logic [EW-1:0]       w_top;
  logic [LW-1:0]       w_level;
  logic                w_full;
  logic                w_empty;

  assign w_reset     = rst | bus.initialize;
  assign w_pending   = (r_edge_pend & IRQ_EDGE) | (bus.irq & ~IRQ_EDGE);
  assign w_req       = w_pending & bus.irq_mask;
  assign w_int_take  = ~w_reset & bus.int_poll & r_ie & (|w_req) & ~bus.dbg_is_brk;
  assign w_vec       = PC_WIDTH'(vec_addr(INT_VEC_BASE, INT_VEC_STRIDE, int'(w_int_id)));
  assign w_take_mask = w_int_take ? (NUM_IRQ'(1) << w_int_id) : '0;
  assign w_push_data = {r_if, r_ie, bus.flags_in, r_pc};

  // Priority encoder: the lowest-numbered requesting channel wins
  always_comb begin
    w_int_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) w_int_id = IDW'(i);
    end
  end

  // Pick exactly one PC action per cycle; lower-priority strobes are dropped whole
  always_comb begin
    w_src     = PC_HOLD;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_restore = 1'b0;
    w_unf_evt = 1'b0;
    if (w_reset) begin
      w_src = PC_RST;
    end else if (w_int_take) begin
      w_src  = PC_VEC;
      w_push = 1'b1;
    end else if (bus.dbg_is_brk && bus.dbg_pc_wr) begin
      w_src = PC_DBG;
    end else if (bus.ex_call) begin
      w_src  = PC_JUMP;
      w_push = 1'b1;
    end else if (bus.ex_jump) begin
      w_src = PC_JUMP;
    end else if (bus.ex_ret_int || bus.ex_ret_sub) begin
      if (w_empty) begin
        w_src     = PC_RST;
        w_unf_evt = 1'b1;
      end else begin
        w_src     = PC_RET;
        w_pop     = 1'b1;
        w_restore = bus.ex_ret_int;
      end
    end else if (bus.fetch) begin
      w_src = PC_INC;
    end
    w_ovf_evt = w_push & w_full;
  end

  // Next-PC multiplexer
  always_comb begin
    w_pc_next = r_pc;
    case (w_src)
      PC_RST:  w_pc_next = RST_PC;
      PC_VEC:  w_pc_next = w_vec;
      PC_DBG:  w_pc_next = bus.dbg_data_in;
      PC_JUMP: w_pc_next = bus.jump_addr;
      PC_RET:  w_pc_next = w_top[PC_WIDTH-1:0];
      PC_INC:  w_pc_next = r_pc + PC_WIDTH'(1);
      default: w_pc_next = r_pc;
    endcase
  end

  // IE/IF update: interrupt entry and return override the STI/CLI strobes
  always_comb begin
    w_ie_next = r_ie;
    w_if_next = r_if;
    if (w_int_take) begin
      w_ie_next = 1'b0;
      w_if_next = 1'b1;
    end else if (w_restore) begin
      w_ie_next = w_top[OFS_IE];
      w_if_next = w_top[OFS_IF];
    end else if (bus.ie_clr) begin
      w_ie_next = 1'b0;
    end else if (bus.ie_set) begin
      w_ie_next = 1'b1;
    end
  end

  // Program counter and interrupt flags
  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_pc <= RST_PC;
      r_ie <= 1'b0;
      r_if <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      r_ie <= w_ie_next;
      r_if <= w_if_next;
    end
  end

  // Edge capture; prev keeps sampling through reset so a held line does not re-fire
  always_ff @(posedge clk) begin
    r_irq_prev <= bus.irq;
    if (w_reset) begin
      r_edge_pend <= '0;
    end else begin
      r_edge_pend <= (r_edge_pend & ~w_take_mask) | (bus.irq & ~r_irq_prev & IRQ_EDGE);
    end
  end

  // Sticky stack errors survive initialize; only rst or the debugger clears them
  always_ff @(posedge clk) begin
    if (rst || bus.dbg_clr_err) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_ovf_evt;
      r_unf <= r_unf | w_unf_evt;
    end
  end

  program_flow_unit_flow_stack #(
    .DATA_WIDTH (EW),
    .DEPTH      (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (w_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_top   (w_top),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.pc          = r_pc;
  assign bus.int_take    = w_int_take;
  assign bus.int_id      = w_int_id;
  assign bus.flag_ie     = r_ie;
  assign bus.flag_if     = r_if;
  assign bus.flags_out   = w_top[OFS_FLAGS +: FLAG_WIDTH];
  assign bus.flags_wr    = w_restore;
  assign bus.stack_top   = w_top;
  assign bus.stack_level = w_level;
  assign bus.stack_ovf   = r_ovf;
  assign bus.stack_unf   = r_unf;

endmodule

// File: tb/tb_program_flow_unit.sv
// tb/tb_program_flow_unit.sv - directed self-checking bench for program_flow_unit
module tb_program_flow_unit;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   takes;

  program_flow_unit_if #(
    .PC_WIDTH(8), .STACK_DEPTH(16), .FLAG_WIDTH(4), .NUM_IRQ(4)
  ) pf_if ();

  program_flow_unit #(
    .PC_WIDTH(8), .STACK_DEPTH(16), .FLAG_WIDTH(4), .NUM_IRQ(4),
    .IRQ_EDGE(4'b0100), .RST_VECTOR(0), .INT_VEC_BASE(1), .INT_VEC_STRIDE(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (pf_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pf_if.initialize  = 1'b0;
    pf_if.fetch       = 1'b0;
    pf_if.ex_jump     = 1'b0;
    pf_if.ex_call     = 1'b0;
    pf_if.ex_ret_sub  = 1'b0;
    pf_if.ex_ret_int  = 1'b0;
    pf_if.int_poll    = 1'b0;
    pf_if.ie_set      = 1'b0;
    pf_if.ie_clr      = 1'b0;
    pf_if.dbg_is_brk  = 1'b0;
    pf_if.dbg_pc_wr   = 1'b0;
    pf_if.dbg_clr_err = 1'b0;
  endtask

  task automatic dbg_write(input logic [7:0] addr);
    pf_if.dbg_is_brk  = 1'b1;
    pf_if.dbg_pc_wr   = 1'b1;
    pf_if.dbg_data_in = addr;
    step();
    idle();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    idle();
    pf_if.jump_addr   = '0;
    pf_if.irq         = '0;
    pf_if.irq_mask    = 4'b1111;
    pf_if.flags_in    = '0;
    pf_if.dbg_data_in = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_pc", 32'(pf_if.pc), 0);
    check("rst_level", 32'(pf_if.stack_level), 0);
    check("rst_top", 32'(pf_if.stack_top), 0);
    check("rst_ie_if", {30'd0, pf_if.flag_if, pf_if.flag_ie}, 0);
    check("rst_err", {30'd0, pf_if.stack_unf, pf_if.stack_ovf}, 0);
    check("rst_take_wr", {30'd0, pf_if.flags_wr, pf_if.int_take}, 0);

    // Fetch and wrap
    pf_if.fetch = 1'b1;
    repeat (5) step();
    idle();
    check("fetch5_pc", 32'(pf_if.pc), 5);
    dbg_write(8'hFF);
    check("dbg_pc_ff", 32'(pf_if.pc), 32'hFF);
    pf_if.fetch = 1'b1;
    step();
    check("wrap_pc_00", 32'(pf_if.pc), 0);
    repeat (255) step();
    idle();
    check("wrap_pc_ff", 32'(pf_if.pc), 32'hFF);

    // Call / return
    dbg_write(8'h10);
    pf_if.ex_call   = 1'b1;
    pf_if.jump_addr = 8'h40;
    pf_if.flags_in  = 4'b0101;
    step();
    idle();
    check("call_pc", 32'(pf_if.pc), 32'h40);
    check("call_level", 32'(pf_if.stack_level), 1);
    check("call_top", 32'(pf_if.stack_top), 32'h0510);
    pf_if.ex_ret_sub = 1'b1;
    #1;
    check("retsub_no_wr", 32'(pf_if.flags_wr), 0);
    step();
    idle();
    check("retsub_pc", 32'(pf_if.pc), 32'h10);
    check("retsub_level", 32'(pf_if.stack_level), 0);

    // Vectored interrupt and return from interrupt
    pf_if.ie_set = 1'b1;
    step();
    idle();
    check("sti_ie", 32'(pf_if.flag_ie), 1);
    pf_if.irq      = 4'b1010;
    pf_if.flags_in = 4'b1001;
    pf_if.int_poll = 1'b1;
    #1;
    check("irq_take", 32'(pf_if.int_take), 1);
    check("irq_id", 32'(pf_if.int_id), 1);
    step();
    idle();
    pf_if.irq      = '0;
    pf_if.flags_in = '0;
    check("irq_pc", 32'(pf_if.pc), 3);
    check("irq_ie_if", {30'd0, pf_if.flag_if, pf_if.flag_ie}, 32'b10);
    check("irq_top", 32'(pf_if.stack_top), 32'h1910);
    pf_if.ex_ret_int = 1'b1;
    #1;
    check("reti_wr", 32'(pf_if.flags_wr), 1);
    check("reti_flags", 32'(pf_if.flags_out), 32'b1001);
    step();
    idle();
    check("reti_pc", 32'(pf_if.pc), 32'h10);
    check("reti_ie_if", {30'd0, pf_if.flag_if, pf_if.flag_ie}, 32'b01);
    check("reti_wr_done", 32'(pf_if.flags_wr), 0);

    // Edge channel 2 held high: taken exactly once
    pf_if.irq = 4'b0100;
    step();
    pf_if.int_poll = 1'b1;
    #1;
    check("edge_take", 32'(pf_if.int_take), 1);
    check("edge_id", 32'(pf_if.int_id), 2);
    step();
    idle();
    check("edge_pc", 32'(pf_if.pc), 5);
    takes = 0;
    for (int i = 0; i < 3; i++) begin
      pf_if.ie_set = 1'b1;
      step();
      idle();
      pf_if.ex_call   = 1'b1;
      pf_if.jump_addr = 8'h20;
      step();
      idle();
      pf_if.ex_ret_int = 1'b1;
      step();
      idle();
      pf_if.int_poll = 1'b1;
      #1;
      if (pf_if.int_take) takes++;
      step();
      idle();
    end
    check("edge_retake", 32'(takes), 0);
    check("edge_level", 32'(pf_if.stack_level), 1);
    pf_if.ex_ret_int = 1'b1;
    step();
    idle();
    check("edge_ret_pc", 32'(pf_if.pc), 32'h10);

    // Level channel 3: retaken at every poll
    pf_if.irq = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      pf_if.int_poll = 1'b1;
      #1;
      check("lvl_take", 32'(pf_if.int_take), 1);
      check("lvl_id", 32'(pf_if.int_id), 3);
      step();
      idle();
      check("lvl_pc", 32'(pf_if.pc), 7);
      pf_if.ex_ret_int = 1'b1;
      step();
      idle();
    end
    pf_if.irq = '0;
    check("lvl_ie", 32'(pf_if.flag_ie), 1);

    // CLI beats STI
    pf_if.ie_set = 1'b1;
    pf_if.ie_clr = 1'b1;
    step();
    idle();
    check("cli_wins", 32'(pf_if.flag_ie), 0);

    // Overflow and underflow
    pf_if.ex_call   = 1'b1;
    pf_if.jump_addr = 8'h40;
    repeat (16) step();
    check("full_no_ovf", 32'(pf_if.stack_ovf), 0);
    step();
    idle();
    check("ovf_flag", 32'(pf_if.stack_ovf), 1);
    check("ovf_level", 32'(pf_if.stack_level), 16);
    check("ovf_pc", 32'(pf_if.pc), 32'h40);
    pf_if.ex_ret_sub = 1'b1;
    repeat (16) step();
    check("pop16_pc", 32'(pf_if.pc), 32'h10);
    check("pop16_unf", 32'(pf_if.stack_unf), 0);
    step();
    idle();
    check("unf_pc", 32'(pf_if.pc), 0);
    check("unf_flag", 32'(pf_if.stack_unf), 1);
    pf_if.dbg_clr_err = 1'b1;
    step();
    idle();
    check("clr_err", {30'd0, pf_if.stack_unf, pf_if.stack_ovf}, 0);

    // Interrupt beats a jump in the same cycle
    pf_if.ie_set = 1'b1;
    step();
    idle();
    pf_if.irq       = 4'b0001;
    pf_if.int_poll  = 1'b1;
    pf_if.ex_jump   = 1'b1;
    pf_if.jump_addr = 8'h55;
    step();
    idle();
    pf_if.irq = '0;
    check("vec_wins_pc", 32'(pf_if.pc), 1);
    check("vec_wins_level", 32'(pf_if.stack_level), 1);
    pf_if.ex_ret_int = 1'b1;
    step();
    idle();
    check("vec_ret_level", 32'(pf_if.stack_level), 0);

    // Break state blocks interrupts; debug PC write lands
    pf_if.irq         = 4'b0001;
    pf_if.int_poll    = 1'b1;
    pf_if.dbg_is_brk  = 1'b1;
    pf_if.dbg_pc_wr   = 1'b1;
    pf_if.dbg_data_in = 8'h77;
    #1;
    check("brk_no_take", 32'(pf_if.int_take), 0);
    step();
    idle();
    pf_if.irq = '0;
    check("brk_pc", 32'(pf_if.pc), 32'h77);
    check("brk_level", 32'(pf_if.stack_level), 0);

    // initialize keeps sticky errors; rst clears them
    pf_if.ex_ret_sub = 1'b1;
    step();
    idle();
    pf_if.fetch  = 1'b1;
    pf_if.ie_set = 1'b1;
    step();
    idle();
    check("pre_init_pc", 32'(pf_if.pc), 1);
    pf_if.initialize = 1'b1;
    step();
    idle();
    check("init_pc", 32'(pf_if.pc), 0);
    check("init_ie", 32'(pf_if.flag_ie), 0);
    check("init_keeps_unf", 32'(pf_if.stack_unf), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clears_unf", 32'(pf_if.stack_unf), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
